// File: rtl/riscv_pkg.sv
// Types and constants shared by the front-end fetch logic.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } fetch_state_e;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: next-PC mux, single-outstanding imem handshake and a
// one-entry instruction buffer toward decode, with redirect/trap flushing.
//
// state   | meaning
// IDLE    | post-reset bubble, PC forced to RESET_PC
// REQ     | request asserted at pc_i until granted
// WAIT    | granted, waiting for read data (flush_pend drops it)
// DELIVER | buffered instruction offered to decode
module fetch_ctrl
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_i,
    output logic [31:0] pc_next_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_tgt_i,
    input  logic        trap_i,
    output logic        misalign_fault_o
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    logic         r_flush_pend;
    logic         w_flush_nxt;
    logic [31:0]  r_instr;
    logic [31:0]  r_instr_pc;
    logic         w_capture;
    logic         w_redir;
    logic         w_misalign;
    logic [31:0]  w_tgt;

    // A misaligned redirect is turned into a trap-vector jump; trap wins outright.
    always_comb begin
        w_redir    = (trap_i || redirect_i) && (r_state != IDLE);
        w_misalign = redirect_i && !trap_i && (redirect_tgt_i[1:0] != 2'b00);
        if (trap_i || w_misalign) begin
            w_tgt = TRAP_VECTOR;
        end else begin
            w_tgt = redirect_tgt_i;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_flush_nxt   = r_flush_pend;
        w_capture     = 1'b0;
        pc_next_o     = pc_i;
        imem_req_o    = 1'b0;
        instr_valid_o = 1'b0;

        case (r_state)
            IDLE: begin
                pc_next_o   = RESET_PC;
                w_state_nxt = REQ;
            end
            REQ: begin
                imem_req_o = 1'b1;
                if (imem_gnt_i) begin
                    w_state_nxt = WAIT;
                    if (w_redir) begin
                        w_flush_nxt = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    w_flush_nxt = 1'b0;
                    if (r_flush_pend || w_redir) begin
                        w_state_nxt = REQ;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = DELIVER;
                    end
                end else if (w_redir) begin
                    w_flush_nxt = 1'b1;
                end
            end
            DELIVER: begin
                if (w_redir) begin
                    w_state_nxt = REQ;
                end else begin
                    instr_valid_o = 1'b1;
                    if (instr_ready_i) begin
                        pc_next_o   = pc_i + INSTR_BYTES;
                        w_state_nxt = REQ;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_redir) begin
            pc_next_o = w_tgt;
        end

        // Reset is synchronous, so the state may still be stale in this cycle.
        if (reset) begin
            pc_next_o     = RESET_PC;
            imem_req_o    = 1'b0;
            instr_valid_o = 1'b0;
        end
    end

    assign imem_addr_o      = reset ? 32'h0 : pc_i;
    assign misalign_fault_o = !reset && w_misalign && (r_state != IDLE);
    assign instr_o          = r_instr;
    assign instr_pc_o       = r_instr_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_flush_pend <= 1'b0;
            r_instr      <= 32'h0;
            r_instr_pc   <= 32'h0;
        end else begin
            r_state      <= w_state_nxt;
            r_flush_pend <= w_flush_nxt;
            if (w_capture) begin
                r_instr    <= imem_rdata_i;
                r_instr_pc <= pc_i;
            end
        end
    end

endmodule
